// File: rtl/lsu_port.sv
// Load/store unit port: one access in flight, IDLE -> ACCESS -> RESP handshake to a simple memory.
// Optional macro LSU_ALIGN_CHECK_EN faults misaligned W/D accesses.
module lsu_port #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_store,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic         readtype,
    output logic [1:0]   memwrite,
    output logic [N-1:0] dataadr,
    output logic [N-1:0] writedata,
    input  logic [N-1:0] readdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [1:0] SizeW = 2'd1;
    localparam logic [1:0] SizeB = 2'd2;

    state_e       r_state;
    state_e       w_state_next;
    logic         r_store;
    logic [1:0]   r_size;
    logic         r_unsigned;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_rdata;
    logic         r_err;

    logic         w_fault;
    logic [N-1:0] w_shifted;
    logic [7:0]   w_byte;
    logic [31:0]  w_word;
    logic [N-1:0] w_load;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_fault = (req_size == 2'd0)
                  || ((req_size == SizeW) && (req_addr[1:0] != 2'b00))
                  || ((req_size == 2'd3) && (req_addr[2:0] != 3'b000));
`else
    assign w_fault = (req_size == 2'd0);
`endif

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        memwrite     = 2'd0;
        readtype     = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_fault ? StResp : StAccess;
                end
            end
            StAccess: begin
                w_state_next = StResp;
                memwrite     = r_store ? r_size : 2'd0;
                readtype     = !r_store && (r_size != SizeW);
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Big-endian byte lane: offset 0 lives in the most significant byte of the dword.
    always_comb begin
        w_shifted = readdata >> {3'd7 - r_addr[2:0], 3'b000};
        w_byte    = w_shifted[7:0];
        w_word    = readdata[31:0];
        w_load    = readdata;
        if (r_size == SizeB) begin
            w_load = {{(N-8){~r_unsigned & w_byte[7]}}, w_byte};
        end else if (r_size == SizeW) begin
            w_load = {{(N-32){~r_unsigned & w_word[31]}}, w_word};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_store    <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && req_valid) begin
                r_store    <= req_store;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                if (w_fault) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
            if (r_state == StAccess) begin
                r_err   <= 1'b0;
                r_rdata <= r_store ? '0 : w_load;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign dataadr    = r_addr;
    assign writedata  = r_wdata;

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port with a big-endian dword memory model and a response scoreboard.
module tb_lsu_port;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_store;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_rdata;
    logic         resp_err;
    logic         readtype;
    logic [1:0]   memwrite;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [N-1:0] readdata;

    logic [63:0] mem [0:7] = '{default: 64'h0};
    logic [2:0]  w_idx;
    logic [5:0]  w_bsh;
    int          n_writes = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [64:0] sb[$];

    lsu_port #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .readtype    (readtype),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    assign w_idx = dataadr[5:3];
    assign w_bsh = {3'd7 - dataadr[2:0], 3'b000};

    always_comb begin
        readdata = '0;
        if (readtype) begin
            readdata = mem[w_idx];
        end else begin
            readdata = {32'h0, dataadr[2] ? mem[w_idx][31:0] : mem[w_idx][63:32]};
        end
    end

    always @(posedge clk) begin
        if (memwrite != 2'd0) begin
            n_writes <= n_writes + 1;
            case (memwrite)
                2'd3: mem[w_idx] <= writedata;
                2'd2: mem[w_idx] <= (mem[w_idx] & ~(64'hFF << w_bsh))
                                  | ({56'h0, writedata[7:0]} << w_bsh);
                default: mem[w_idx] <= dataadr[2] ? {mem[w_idx][63:32], writedata[31:0]}
                                                  : {writedata[31:0], mem[w_idx][31:0]};
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rdata, input logic exp_err, input int hold);
        int          lat;
        int          w0;
        logic [64:0] e;
        sb.push_back({exp_err, exp_rdata});
        @(negedge clk);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        w0           = n_writes;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, " latency"}, 64'(lat), exp_err ? 64'd1 : 64'd2);
        e = sb.pop_front();
        check({tag, " rdata"}, resp_rdata, e[63:0]);
        check({tag, " err"}, 64'(resp_err), 64'(e[64]));
        check({tag, " writes"}, 64'(n_writes - w0), (st && !exp_err) ? 64'd1 : 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
            check({tag, " hold rdata"}, resp_rdata, e[63:0]);
            check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
            check({tag, " hold memwrite"}, 64'(memwrite), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " released"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b0;
        #12;
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_err", 64'(resp_err), 64'd0);
        check("rst resp_rdata", resp_rdata, 64'd0);
        check("rst memwrite", 64'(memwrite), 64'd0);
        check("rst readtype", 64'(readtype), 64'd0);
        check("rst dataadr", dataadr, 64'd0);
        check("rst writedata", writedata, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        access("d_st", 1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'h0, 0, 0);
        check("mem2 d_st", mem[2], 64'h1122334455667788);
        access("d_ld", 0, 2'd3, 0, 64'h10, 64'h0, 64'h1122334455667788, 0, 0);
        access("b_st", 1, 2'd2, 1, 64'h13, 64'hAB, 64'h0, 0, 0);
        check("mem2 b_st", mem[2], 64'h112233AB55667788);
        access("b_ld_s", 0, 2'd2, 0, 64'h13, 64'h0, 64'hFFFFFFFFFFFFFFAB, 0, 0);
        access("b_ld_u", 0, 2'd2, 1, 64'h13, 64'h0, 64'h00000000000000AB, 0, 0);
        access("b_ld0", 0, 2'd2, 0, 64'h10, 64'h0, 64'h11, 0, 0);
        access("b_ld7", 0, 2'd2, 0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 0);
        access("w_st", 1, 2'd1, 0, 64'h0C, 64'h80000001, 64'h0, 0, 0);
        check("mem1 w_st", mem[1], 64'h0000000080000001);
        access("w_ld_s", 0, 2'd1, 0, 64'h0C, 64'h0, 64'hFFFFFFFF80000001, 0, 0);
        access("w_ld_u", 0, 2'd1, 1, 64'h0C, 64'h0, 64'h0000000080000001, 0, 0);
        access("w_ld_hi", 0, 2'd1, 0, 64'h10, 64'h0, 64'h00000000112233AB, 0, 0);
        access("sz0", 1, 2'd0, 0, 64'h18, 64'h5555, 64'h0, 1, 0);
        check("mem3 sz0", mem[3], 64'h0);
        access("hold", 0, 2'd3, 0, 64'h10, 64'h0, 64'h112233AB55667788, 0, 5);
`ifdef LSU_ALIGN_CHECK_EN
        access("w_mis", 1, 2'd1, 0, 64'h0E, 64'hCAFEF00D, 64'h0, 1, 0);
        check("mem1 w_mis", mem[1], 64'h0000000080000001);
        access("d_mis", 0, 2'd3, 0, 64'h13, 64'h0, 64'h0, 1, 0);
`else
        access("w_mis", 1, 2'd1, 0, 64'h0E, 64'hCAFEF00D, 64'h0, 0, 0);
        check("mem1 w_mis", mem[1], 64'h00000000CAFEF00D);
        access("d_mis", 0, 2'd3, 0, 64'h13, 64'h0, 64'h112233AB55667788, 0, 0);
`endif

        // Reset in the middle of a dword store's ACCESS cycle.
        @(negedge clk);
        req_store = 1'b1;
        req_size  = 2'd3;
        req_addr  = 64'h20;
        req_wdata = 64'hDEADBEEFCAFEF00D;
        req_valid = 1'b1;
        w0        = n_writes;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_acc memwrite pre", 64'(memwrite), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("rst_acc memwrite", 64'(memwrite), 64'd0);
        check("rst_acc req_ready", 64'(req_ready), 64'd1);
        check("rst_acc resp_valid", 64'(resp_valid), 64'd0);
        check("rst_acc dataadr", dataadr, 64'd0);
        @(posedge clk);
        #1;
        check("rst_acc writes", 64'(n_writes - w0), 64'd0);
        check("rst_acc mem4", mem[4], 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_acc no resp", 64'(resp_valid), 64'd0);
        check("rst_acc idle", 64'(req_ready), 64'd1);
        access("post_rst", 0, 2'd3, 0, 64'h20, 64'h0, 64'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
